instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Program loader for the 8-bit processor's 32-entry, 16-bit instruction memory. It accepts a byte stream through a valid/ready handshake and packs byte pairs into instruction words, high byte first. It writes each word through the instruction memory's write port, then checks a trailing XOR checksum byte. While a load is in progress it holds the processor's fetch/PC logic via cpu_hold.

Parameters:
DEPTH, 32, number of instruction words (max load length)
ADDR_W, 5, instruction memory address width
DATA_W, 16, instruction word width (two bytes)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle load request, honoured only in IDLE/DONE/ERR
num_words  input  6  words to load, valid range 1..DEPTH, sampled on start
byte_in  input  8  incoming program byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader accepts byte this cycle
wr_en  output  1  instruction memory write strobe, one cycle per word
wr_addr  output  ADDR_W  instruction memory write address
wr_data  output  DATA_W  instruction word {hi_byte, lo_byte}
cpu_hold  output  1  stalls processor PC/fetch while high
words_loaded  output  6  count of words written in current load
done  output  1  load finished with good checksum (level)
error  output  1  bad num_words or checksum mismatch (level)

Behaviour:
- Reset (async, rst_n=0): state IDLE. byte_ready, wr_en, cpu_hold, done and error are 0. wr_addr=0, wr_data=0, words_loaded=0, checksum accumulator=0.
- Handshake: a byte transfers on a rising edge with byte_valid=1 and byte_ready=1. byte_ready is never combinationally dependent on byte_valid.
- States: IDLE, HI, LO, WRITE, CHK, DONE, ERR.
- IDLE/DONE/ERR with start=1:
  - num_words in 1..32: latch count, clear words_loaded, wr_addr and checksum, clear done/error, set cpu_hold=1, go to HI.
  - num_words=0 or >32: go to ERR, cpu_hold unchanged.
- HI: byte_ready=1. On transfer, latch high byte, checksum ^= byte, go to LO.
- LO: byte_ready=1. On transfer, latch low byte, checksum ^= byte, go to WRITE.
- WRITE (one cycle): byte_ready=0, wr_en=1, wr_data={hi,lo}, wr_addr=current address. Next edge: wr_addr+1, words_loaded+1. If the new words_loaded equals count, go to CHK, else go to HI.
  - wr_addr is 5 bits; a 32-word load ends with wr_addr wrapped to 0. No write occurs beyond index 31.
- CHK: byte_ready=1. On transfer:
  - byte equals accumulated checksum: go to DONE.
  - otherwise: go to ERR.
- DONE: done=1, cpu_hold=0, byte_ready=0. Processor resumes fetching.
- ERR: error=1, cpu_hold keeps its value (stays 1 on a failed load), byte_ready=0.
- start in HI/LO/WRITE/CHK is ignored. A byte offered in IDLE/DONE/ERR/WRITE is not accepted.
- Word write latency: wr_en is high the cycle after the low-byte transfer. Minimum 3 cycles per word.
- rst_n asserted mid-load: immediate return to reset values. Partially written words stay in memory; cpu_hold drops.
- wr_en, wr_addr and wr_data are registered outputs.

Test Plan:
- Reset then idle: rst_n low, byte_valid=1 -> byte_ready=0, wr_en=0, cpu_hold=0, done=0, error=0.
- 2-word load: start, num_words=2; bytes 04,40,04,41, checksum 01 -> writes 0x0440@0 and 0x0441@1. Each wr_en is one cycle after the low byte. words_loaded=2, done=1, cpu_hold=0.
- Bad checksum: same stream, checksum byte 00 -> both words written, error=1, cpu_hold=1, done=0.
- Invalid length: start with num_words=0 and then 33 -> ERR immediately, error=1, no wr_en, byte_ready=0.
- Backpressure/gaps: byte_valid toggled randomly during a 32-word load of value 0x1000+i -> every word written at addr i. wr_addr wraps to 0, done=1, start pulses mid-load ignored.
- Reset mid-load: rst_n low after 3 words of 8 -> all outputs at reset values. A new start with num_words=1 loads cleanly at addr 0.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// ============================================================================
// Module   : instr_mem_loader_if
// Purpose  : Byte-stream handshake and instruction-memory write port bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface instr_mem_loader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // master: the loader itself; slave: byte source plus instruction memory
  modport master (
    input  byte_in, byte_valid,
    output byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output byte_in, byte_valid,
    input  byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// ============================================================================
// Module   : instr_mem_loader
// Purpose  : Packs a byte stream into 16-bit instruction words, writes them,
//            verifies a trailing XOR checksum and holds the CPU meanwhile.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_mem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [5:0]          num_words,
  instr_mem_loader_if.master  bus,
  output logic                cpu_hold,
  output logic [5:0]          words_loaded,
  output logic                done,
  output logic                error
);

  localparam logic [5:0] C_DEPTH = 6'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        chk_q, chk_d;
  logic [5:0]        count_q, count_d;
  logic [5:0]        loaded_q, loaded_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic              hold_q, hold_d;

  logic              w_ready;
  logic              w_xfer;
  logic              w_len_ok;

  // Ready is a pure state decode so it never loops back through byte_valid
  assign w_ready  = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_CHK);
  assign w_xfer   = w_ready && bus.byte_valid;
  assign w_len_ok = (num_words != 6'd0) && (num_words <= C_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      chk_q    <= '0;
      count_q  <= '0;
      loaded_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_en_q  <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      chk_q    <= chk_d;
      count_q  <= count_d;
      loaded_q <= loaded_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_en_q  <= wr_en_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    chk_d    = chk_q;
    count_d  = count_q;
    loaded_d = loaded_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_en_d  = 1'b0;
    hold_d   = hold_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if (w_len_ok) begin
            count_d  = num_words;
            loaded_d = '0;
            addr_d   = '0;
            chk_d    = '0;
            hold_d   = 1'b1;
            state_d  = S_HI;
          end else begin
            state_d  = S_ERR;
          end
        end
      end

      S_HI: begin
        if (w_xfer) begin
          hi_d    = bus.byte_in;
          chk_d   = chk_q ^ bus.byte_in;
          state_d = S_LO;
        end
      end

      // Word and strobe are registered here so they appear during WRITE
      S_LO: begin
        if (w_xfer) begin
          data_d  = DATA_W'({hi_q, bus.byte_in});
          chk_d   = chk_q ^ bus.byte_in;
          wr_en_d = 1'b1;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        addr_d   = addr_q + 1'b1;
        loaded_d = loaded_q + 6'd1;
        state_d  = ((loaded_q + 6'd1) == count_q) ? S_CHK : S_HI;
      end

      S_CHK: begin
        if (w_xfer) begin
          if (bus.byte_in == chk_q) begin
            hold_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.byte_ready = w_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = addr_q;
  assign bus.wr_data    = data_q;
  assign cpu_hold       = hold_q;
  assign words_loaded   = loaded_q;
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_ERR);

  a_wr_single : assert property (@(posedge clk) disable iff (!rst_n)
    wr_en_q |=> !wr_en_q);
  a_ready_idle : assert property (@(posedge clk) disable iff (!rst_n)
    (done || error) |-> !w_ready);
  a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
    loaded_q <= C_DEPTH);

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
// Module   : tb_instr_mem_loader
// Purpose  : Table-driven and randomised self-checking bench for the loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_mem_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] num_words = '0;
  logic       cpu_hold, done, error;
  logic [5:0] words_loaded;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  logic        m_hold   = 1'b0;
  logic [15:0] ld_words [32];

  instr_mem_loader_if #(.ADDR_W(5), .DATA_W(16)) bus ();

  instr_mem_loader #(.DEPTH(32), .ADDR_W(5), .DATA_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_words    (num_words),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .words_loaded (words_loaded),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
    int unsigned c;
  } wr_t;

  wr_t         wr_q [$];
  int unsigned exp_c_q [$];

  always @(negedge clk)
    if (bus.wr_en === 1'b1) wr_q.push_back('{bus.wr_addr, bus.wr_data, cyc});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit is_lo, input bit noise);
    bit sent = 0;
    for (int k = 0; k < 300 && !sent; k++) begin
      @(negedge clk);
      start          = noise && ($urandom_range(99) < 5);
      num_words      = 6'($urandom_range(63));
      bus.byte_valid = ($urandom_range(99) >= gap);
      bus.byte_in    = bus.byte_valid ? b : 8'($urandom);
      #1;
      if (bus.byte_valid && bus.byte_ready) begin
        sent = 1;
        if (is_lo) exp_c_q.push_back(cyc + 1);
      end
    end
    if (!sent) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_timeout: byte 0x%0h not accepted, required within 300 cycles", b);
    end
  endtask

  task automatic run_load(input int n, input bit use_chk, input logic [7:0] chk_in,
                          input int gap, input bit noise, input bit exp_good);
    logic [7:0] x;
    logic [7:0] cb;
    int         bad;
    wr_q.delete();
    exp_c_q.delete();
    @(negedge clk);
    start = 1'b1; num_words = 6'(n); bus.byte_valid = 1'b0;
    @(negedge clk); #1;
    start = 1'b0;
    check("hold_during_load", cpu_hold, 1);
    check("flags_during_load", {done, error}, 0);
    x = '0;
    for (int i = 0; i < n; i++) begin
      send_byte(ld_words[i][15:8], gap, 0, noise);
      send_byte(ld_words[i][7:0],  gap, 1, noise);
      x = x ^ ld_words[i][15:8] ^ ld_words[i][7:0];
    end
    cb = use_chk ? chk_in : x;
    send_byte(cb, gap, 0, noise);
    @(negedge clk);
    start = 1'b0; bus.byte_valid = 1'b1; bus.byte_in = 8'hA5;
    #1;
    check("done_level", done, exp_good);
    check("error_level", error, !exp_good);
    check("cpu_hold_end", cpu_hold, !exp_good);
    check("ready_after_load", bus.byte_ready, 0);
    check("words_loaded", words_loaded, n);
    check("wr_addr_end", bus.wr_addr, n % 32);
    @(negedge clk); #1;
    bus.byte_valid = 1'b0;
    check("done_held", {done, error}, {exp_good, !exp_good});
    check("num_writes", wr_q.size(), n);
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++) begin
      if (i >= n || wr_q[i].addr != 5'(i) || wr_q[i].data != ld_words[i] ||
          i >= exp_c_q.size() || wr_q[i].c != exp_c_q[i]) begin
        if (bad == 0)
          $display("first bad write %0d: addr %0d data 0x%0h cyc %0d", i,
                   wr_q[i].addr, wr_q[i].data, wr_q[i].c);
        bad++;
      end
    end
    check("write_contents", bad, 0);
    m_hold = !exp_good;
  endtask

  task automatic bad_len(input int n);
    wr_q.delete();
    @(negedge clk);
    start = 1'b1; num_words = 6'(n); bus.byte_valid = 1'b1; bus.byte_in = 8'h12;
    @(negedge clk); #1;
    start = 1'b0;
    check("badlen_error", error, 1);
    check("badlen_done", done, 0);
    check("badlen_ready", bus.byte_ready, 0);
    check("badlen_hold", cpu_hold, m_hold);
    @(negedge clk); #1;
    bus.byte_valid = 1'b0;
    check("badlen_no_write", wr_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  bus.byte_ready, 0);
    check({tag, "_wr_en"},  bus.wr_en, 0);
    check({tag, "_addr"},   bus.wr_addr, 0);
    check({tag, "_data"},   bus.wr_data, 0);
    check({tag, "_hold"},   cpu_hold, 0);
    check({tag, "_loaded"}, words_loaded, 0);
    check({tag, "_flags"},  {done, error}, 0);
  endtask

  typedef struct {
    int          nw;
    logic [15:0] base;
    bit          use_chk;
    logic [7:0]  chk;
    int          gap;
    bit          noise;
    bit          exp_done;
  } vec_t;

  vec_t vt [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x;
    int         n;
    bit         use_chk;
    logic [7:0] chk;
    bit         waited;

    vt[0] = '{2,  16'h0440, 1, 8'h01, 0,  0, 1};
    vt[1] = '{2,  16'h0440, 1, 8'h00, 0,  0, 0};
    vt[2] = '{0,  16'h0000, 0, 8'h00, 0,  0, 0};
    vt[3] = '{33, 16'h0000, 0, 8'h00, 0,  0, 0};
    vt[4] = '{32, 16'h1000, 0, 8'h00, 40, 1, 1};
    vt[5] = '{1,  16'hBEEF, 1, 8'h51, 20, 0, 1};

    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'hFF;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    bus.byte_valid = 1'b0;
    m_hold = 1'b0;

    for (int v = 0; v < 6; v++) begin
      if (vt[v].nw >= 1 && vt[v].nw <= 32) begin
        for (int i = 0; i < vt[v].nw; i++) ld_words[i] = vt[v].base + 16'(i);
        run_load(vt[v].nw, vt[v].use_chk, vt[v].chk, vt[v].gap, vt[v].noise, vt[v].exp_done);
      end else begin
        bad_len(vt[v].nw);
      end
    end

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(32, 1);
      x = '0;
      for (int i = 0; i < n; i++) begin
        ld_words[i] = 16'($urandom);
        x = x ^ ld_words[i][15:8] ^ ld_words[i][7:0];
      end
      use_chk = ($urandom_range(1) == 1);
      chk     = 8'($urandom);
      run_load(n, use_chk, chk, $urandom_range(60), 1, !use_chk || (chk == x));
    end

    wr_q.delete();
    exp_c_q.delete();
    @(negedge clk);
    start = 1'b1; num_words = 6'd8;
    for (int i = 0; i < 8; i++) ld_words[i] = 16'hC000 + 16'(i);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_byte(ld_words[i][15:8], 0, 0, 0);
      send_byte(ld_words[i][7:0],  0, 1, 0);
    end
    waited = 0;
    for (int k = 0; k < 20 && !waited; k++) begin
      @(negedge clk); #1;
      if (wr_q.size() >= 3) waited = 1;
    end
    check("partial_writes", wr_q.size(), 3);
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h77;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.byte_valid = 1'b0;
    m_hold = 1'b0;
    ld_words[0] = 16'h5A3C;
    run_load(1, 0, 8'h00, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
